// File: rtl/gate_sensor_pkg.sv
// Shared types and default constants for the gate sensor conditioner.
package gate_sensor_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } chan_state_e;

  localparam int unsigned DEBOUNCE_DEFAULT = 50000;
  localparam int unsigned GLITCH_W_DEFAULT = 8;

endpackage

// File: rtl/debounce_channel.sv
// One sensor channel: 2-flop synchronizer, persistence debouncer, edge pulses
// and a saturating counter of rejected short excursions.
module debounce_channel
  import gate_sensor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned GLITCH_W        = GLITCH_W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                raw_i,
  output logic                clean_o,
  output logic                rise_o,
  output logic                fall_o,
  output logic [GLITCH_W-1:0] glitches_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // Value held while the final persistence cycle is being evaluated.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                meta_q;
  logic                sync_q;
  chan_state_e         state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                clean_q;
  logic                rise_q;
  logic                fall_q;
  logic [GLITCH_W-1:0] glitch_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= STABLE;
      cnt_q    <= '0;
      clean_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        STABLE: begin
          cnt_q <= '0;
          if (sync_q != clean_q) begin
            if (DEBOUNCE_CYCLES == 1) begin
              clean_q <= sync_q;
              rise_q  <= sync_q;
              fall_q  <= ~sync_q;
            end else begin
              state_q <= PENDING;
              cnt_q   <= CNT_W'(1);
            end
          end
        end
        PENDING: begin
          if (sync_q == clean_q) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            if (glitch_q != '1) glitch_q <= glitch_q + GLITCH_W'(1);
          end else if (cnt_q == CNT_LAST) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            clean_q <= sync_q;
            rise_q  <= sync_q;
            fall_q  <= ~sync_q;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= STABLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign clean_o    = clean_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign glitches_o = glitch_q;

endmodule

// File: rtl/gate_sensor_conditioner.sv
// Conditions the outer and inner gate sensors into clean levels, edge pulses
// and glitch statistics; the two channels are fully independent.
module gate_sensor_conditioner
  import gate_sensor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned GLITCH_W        = GLITCH_W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                outer_raw,
  input  logic                inner_raw,
  output logic                outer,
  output logic                inner,
  output logic                outer_rise,
  output logic                outer_fall,
  output logic                inner_rise,
  output logic                inner_fall,
  output logic [GLITCH_W-1:0] outer_glitches,
  output logic [GLITCH_W-1:0] inner_glitches
);

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .GLITCH_W        (GLITCH_W)
  ) u_outer (
    .clk        (clk),
    .reset      (reset),
    .raw_i      (outer_raw),
    .clean_o    (outer),
    .rise_o     (outer_rise),
    .fall_o     (outer_fall),
    .glitches_o (outer_glitches)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .GLITCH_W        (GLITCH_W)
  ) u_inner (
    .clk        (clk),
    .reset      (reset),
    .raw_i      (inner_raw),
    .clean_o    (inner),
    .rise_o     (inner_rise),
    .fall_o     (inner_fall),
    .glitches_o (inner_glitches)
  );

endmodule

// File: tb/tb_gate_sensor_conditioner.sv
// Directed bench: a DEBOUNCE_CYCLES=4 instance for the main behaviour and a
// DEBOUNCE_CYCLES=1 instance for the immediate-accept build.
module tb_gate_sensor_conditioner;

  logic       clk;
  logic       reset;
  logic       a_outer_raw, a_inner_raw;
  logic       a_outer, a_inner, a_outer_rise, a_outer_fall, a_inner_rise, a_inner_fall;
  logic [7:0] a_outer_gl, a_inner_gl;
  logic       b_outer_raw, b_inner_raw;
  logic       b_outer, b_inner, b_outer_rise, b_outer_fall, b_inner_rise, b_inner_fall;
  logic [7:0] b_outer_gl, b_inner_gl;

  int checks = 0;
  int errors = 0;

  gate_sensor_conditioner #(.DEBOUNCE_CYCLES(4), .GLITCH_W(8)) dut_a (
    .clk            (clk),
    .reset          (reset),
    .outer_raw      (a_outer_raw),
    .inner_raw      (a_inner_raw),
    .outer          (a_outer),
    .inner          (a_inner),
    .outer_rise     (a_outer_rise),
    .outer_fall     (a_outer_fall),
    .inner_rise     (a_inner_rise),
    .inner_fall     (a_inner_fall),
    .outer_glitches (a_outer_gl),
    .inner_glitches (a_inner_gl)
  );

  gate_sensor_conditioner #(.DEBOUNCE_CYCLES(1), .GLITCH_W(8)) dut_b (
    .clk            (clk),
    .reset          (reset),
    .outer_raw      (b_outer_raw),
    .inner_raw      (b_inner_raw),
    .outer          (b_outer),
    .inner          (b_inner),
    .outer_rise     (b_outer_rise),
    .outer_fall     (b_outer_fall),
    .inner_rise     (b_inner_rise),
    .inner_fall     (b_inner_fall),
    .outer_glitches (b_outer_gl),
    .inner_glitches (b_inner_gl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic seen;

  initial begin
    reset       = 1'b1;
    a_outer_raw = 1'b0;
    a_inner_raw = 1'b0;
    b_outer_raw = 1'b0;
    b_inner_raw = 1'b0;
    step(3);
    chk("rst_a_levels", {30'd0, a_outer, a_inner}, 32'd0);
    chk("rst_a_pulses", {28'd0, a_outer_rise, a_outer_fall, a_inner_rise, a_inner_fall}, 32'd0);
    chk("rst_a_glitch", {16'd0, a_outer_gl, a_inner_gl}, 32'd0);
    chk("rst_b_all", {12'd0, b_outer, b_inner, b_outer_rise, b_outer_fall,
                      b_inner_rise, b_inner_fall, b_outer_gl, b_inner_gl}, 32'd0);
    reset = 1'b0;
    step(8);
    chk("release_no_pulse", {28'd0, a_outer_rise, a_outer_fall, a_inner_rise, a_inner_fall}, 32'd0);
    chk("release_levels", {30'd0, a_outer, a_inner}, 32'd0);

    // Outer rise: sampled at edge 0, accepted at edge 5.
    a_outer_raw = 1'b1;
    step(5);
    chk("rise_e4_outer", {31'd0, a_outer}, 32'd0);
    chk("rise_e4_pulse", {31'd0, a_outer_rise}, 32'd0);
    step(1);
    chk("rise_e5_outer", {31'd0, a_outer}, 32'd1);
    chk("rise_e5_pulse", {31'd0, a_outer_rise}, 32'd1);
    step(1);
    chk("rise_e6_pulse", {31'd0, a_outer_rise}, 32'd0);
    chk("rise_e6_outer", {31'd0, a_outer}, 32'd1);
    chk("rise_glitch", {24'd0, a_outer_gl}, 32'd0);

    // Inner 2-cycle excursion is rejected and counted.
    a_inner_raw = 1'b1;
    step(2);
    a_inner_raw = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      seen = seen | a_inner | a_inner_rise | a_inner_fall;
    end
    chk("short_inner_quiet", {31'd0, seen}, 32'd0);
    chk("short_inner_glitch", {24'd0, a_inner_gl}, 32'd1);

    // Settle inner high, then drop both together.
    a_inner_raw = 1'b1;
    step(8);
    chk("settle_levels", {30'd0, a_outer, a_inner}, 32'd3);
    a_outer_raw = 1'b0;
    a_inner_raw = 1'b0;
    step(5);
    chk("fall_e4", {28'd0, a_outer_fall, a_inner_fall, a_outer, a_inner}, 32'h3);
    step(1);
    chk("fall_e5", {28'd0, a_outer_fall, a_inner_fall, a_outer, a_inner}, 32'hC);
    step(1);
    chk("fall_e6", {28'd0, a_outer_fall, a_inner_fall, a_outer, a_inner}, 32'h0);

    // 300 one-cycle glitches on outer saturate the counter at 255.
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      a_outer_raw = 1'b1;
      step(1);
      a_outer_raw = 1'b0;
      step(2);
      seen = seen | a_outer | a_outer_rise | a_outer_fall;
      if (i == 9) chk("glitch_10", {24'd0, a_outer_gl}, 32'd9);
    end
    step(4);
    seen = seen | a_outer;
    chk("glitch_sat", {24'd0, a_outer_gl}, 32'd255);
    chk("glitch_outer_quiet", {31'd0, seen}, 32'd0);
    chk("glitch_inner_indep", {24'd0, a_inner_gl}, 32'd1);

    // Reset in the middle of a pending rise discards it.
    a_outer_raw = 1'b1;
    step(3);
    reset = 1'b1;
    #1;
    chk("midrst_levels", {30'd0, a_outer, a_inner}, 32'd0);
    chk("midrst_glitch", {16'd0, a_outer_gl, a_inner_gl}, 32'd0);
    step(2);
    chk("midrst_pulses", {28'd0, a_outer_rise, a_outer_fall, a_inner_rise, a_inner_fall}, 32'd0);
    reset = 1'b0;
    step(5);
    chk("postrst_e4", {30'd0, a_outer, a_outer_rise}, 32'd0);
    step(1);
    chk("postrst_e5", {30'd0, a_outer, a_outer_rise}, 32'd3);
    step(1);
    chk("postrst_e6", {30'd0, a_outer, a_outer_rise}, 32'd2);

    // DEBOUNCE_CYCLES=1: accept at edge 2, single-cycle pulse passes through.
    b_outer_raw = 1'b1;
    step(2);
    chk("d1_e1_outer", {30'd0, b_outer, b_outer_rise}, 32'd0);
    step(1);
    chk("d1_e2_outer", {30'd0, b_outer, b_outer_rise}, 32'd3);
    b_inner_raw = 1'b1;
    step(1);
    b_inner_raw = 1'b0;
    step(1);
    chk("d1_pulse_e1", {29'd0, b_inner, b_inner_rise, b_inner_fall}, 32'd0);
    step(1);
    chk("d1_pulse_e2", {29'd0, b_inner, b_inner_rise, b_inner_fall}, 32'd6);
    step(1);
    chk("d1_pulse_e3", {29'd0, b_inner, b_inner_rise, b_inner_fall}, 32'd1);
    chk("d1_glitch", {16'd0, b_outer_gl, b_inner_gl}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_sensor_conditioner.md
GATE_SENSOR_CONDITIONER -- requirements
Module: gate_sensor_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, number of consecutive synchronized cycles a new level must persist before acceptance (1 ms at 50 MHz); legal range 1..2^20.
REQ-002 Parameter GLITCH_W, default 8, width of each glitch counter.
REQ-003 clk  input  1  single system clock (50 MHz CLOCK_50); all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 outer_raw  input  1  unsynchronized outer gate sensor level (breadboard switch/photo-sensor).
REQ-006 inner_raw  input  1  unsynchronized inner gate sensor level.
REQ-007 outer  output  1  debounced outer level, feeds the car detection FSM.
REQ-008 inner  output  1  debounced inner level, feeds the car detection FSM.
REQ-009 outer_rise, outer_fall, inner_rise, inner_fall  output  1 each  single-cycle edge pulses of the debounced levels.
REQ-010 outer_glitches, inner_glitches  output  GLITCH_W each  count of rejected (too-short) transitions per channel.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchronizer; the second flop output (sync) is the only value the debouncer observes.
REQ-012 Each channel SHALL run an independent FSM with states STABLE and PENDING, plus a counter of width $clog2(DEBOUNCE_CYCLES+1).
- STABLE: sync == clean -> stay, counter = 0; sync != clean -> PENDING, counter = 1 (if DEBOUNCE_CYCLES == 1, accept immediately per REQ-013).
- PENDING: sync == clean -> STABLE, counter = 0, glitch counter +1; sync != clean -> counter +1.
REQ-013 When the counter reaches DEBOUNCE_CYCLES with sync != clean, clean SHALL take sync's value on that edge and the FSM SHALL return to STABLE with counter = 0.
REQ-014 Latency: raw change first sampled at edge k, held stable -> clean changes at edge k+DEBOUNCE_CYCLES+1.
REQ-015 rise (fall) SHALL be high for exactly the one cycle after the edge at which clean goes 0->1 (1->0); registered, coincident with the clean change.
REQ-016 A sync excursion lasting fewer than DEBOUNCE_CYCLES cycles SHALL produce no change on clean and no edge pulse.
REQ-017 Glitch counters SHALL saturate at 2^GLITCH_W-1 and never wrap.
REQ-018 Channels SHALL be fully independent; simultaneous transitions on both channels SHALL produce pulses on the same cycle with no priority or interlock.
REQ-019 No combinational path from any raw input to any output.

Reset
REQ-020 reset SHALL asynchronously clear synchronizer flops, clean levels (outer=inner=0), all edge pulses, FSMs to STABLE, debounce counters and glitch counters to 0.
REQ-021 reset asserted mid-PENDING SHALL discard the pending transition; after deassertion a raw level of 1 SHALL be accepted via the normal path as a rise (REQ-014/015).
REQ-022 Release of reset produces no edge pulse by itself.

Structure
REQ-023 Package gate_sensor_pkg SHALL hold the channel state enum (STABLE, PENDING) and the default constants DEBOUNCE_DEFAULT = 50000, GLITCH_W_DEFAULT = 8.
REQ-024 One sub-module debounce_channel (synchronizer + FSM + counter + edge + glitch logic) SHALL be instantiated twice, once per sensor.

Verification (DEBOUNCE_CYCLES = 4)
REQ-025 outer_raw 0->1 sampled at edge 0, held -> outer = 1 and outer_rise = 1 for one cycle after edge 5; glitch count stays 0.
REQ-026 inner_raw high for 2 cycles then low -> inner stays 0, no pulses, inner_glitches = 1.
REQ-027 Both raw inputs 1->0 on the same cycle from settled 1 -> outer_fall and inner_fall both assert in the same cycle, 5 edges later.
REQ-028 300 short glitches on outer_raw -> outer_glitches = 255, outer unchanged at 0.
REQ-029 reset pulsed 2 cycles into a PENDING rise with outer_raw held 1 -> all outputs 0 during reset; outer_rise occurs after the full 5-edge latency measured from the first post-reset sampling edge.
REQ-030 DEBOUNCE_CYCLES = 1 build: raw change sampled at edge 0 -> clean changes at edge 2; 1-cycle raw pulse is passed through.
